// File: rtl/axi_reg_slice_pkg.sv
// axi_reg_slice_pkg: mode encodings and stall counter width shared by the register slice
package axi_reg_slice_pkg;
  localparam int MODE_BYPASS = 0;
  localparam int MODE_FWD = 1;
  localparam int MODE_BWD = 2;
  localparam int MODE_FULL = 3;
  localparam int STALL_CNT_W = 32;
endpackage

// File: rtl/axi_reg_slice_skid.sv
// axi_reg_slice_skid: backward stage with registered ready and a one-beat skid buffer
module axi_reg_slice_skid #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_up,
  input  logic              valid_up,
  output logic              ready_up,
  output logic [DATA_W-1:0] data_down,
  output logic              valid_down,
  input  logic              ready_down
);
  logic              skid_v, skid_v_nxt, rdy_q, acc_up;
  logic [DATA_W-1:0] skid_data;
  assign ready_up = rdy_q && !rst;
  assign acc_up = valid_up && ready_up;
  assign valid_down = acc_up || skid_v;
  assign data_down = skid_v ? skid_data : data_up;
  always_comb skid_v_nxt = skid_v ? !ready_down : acc_up && !ready_down;
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_v <= 1'b0;
      rdy_q <= 1'b1;
      skid_data <= '0;
    end else begin
      skid_v <= skid_v_nxt;
      rdy_q <= !skid_v_nxt;
      if (acc_up && !skid_v && !ready_down) skid_data <= data_up;
    end
  end
endmodule

// File: rtl/axi_reg_slice.sv
// axi_reg_slice: AXI4 channel register slice, MODE 0..3; AXI_REG_SLICE_STALL_CNT_EN adds stall_clr/stall_cnt
module axi_reg_slice
  import axi_reg_slice_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int MODE = MODE_FULL
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      data_up,
  input  logic                   valid_up,
  output logic                   ready_up,
  output logic [DATA_W-1:0]      data_down,
  output logic                   valid_down,
  input  logic                   ready_down
`ifdef AXI_REG_SLICE_STALL_CNT_EN
  ,
  input  logic                   stall_clr,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid, s_ready;
  if (MODE < MODE_BYPASS || MODE > MODE_FULL) begin : g_bad
    $error("axi_reg_slice: MODE must be 0..3");
  end
  if (MODE == MODE_BWD || MODE == MODE_FULL) begin : g_skid
    axi_reg_slice_skid #(.DATA_W(DATA_W)) u_skid (
      .clk(clk),
      .rst(rst),
      .data_up(data_up),
      .valid_up(valid_up),
      .ready_up(ready_up),
      .data_down(s_data),
      .valid_down(s_valid),
      .ready_down(s_ready)
    );
  end else begin : g_noskid
    assign s_data = data_up;
    assign s_valid = valid_up;
    assign ready_up = s_ready;
  end
  if (MODE == MODE_FWD || MODE == MODE_FULL) begin : g_fwd
    logic              v_q;
    logic [DATA_W-1:0] d_q;
    assign s_ready = !rst && (ready_down || !v_q);
    assign valid_down = v_q;
    assign data_down = d_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        d_q <= '0;
      end else if (s_valid && s_ready) begin
        v_q <= 1'b1;
        d_q <= s_data;
      end else if (ready_down) begin
        v_q <= 1'b0;
      end
    end
  end else begin : g_nofwd
    assign data_down = s_data;
    assign valid_down = s_valid;
    assign s_ready = ready_down;
  end
`ifdef AXI_REG_SLICE_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || stall_clr) stall_cnt <= '0;
    else if (valid_down && !ready_down && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_axi_reg_slice.sv
// tb_axi_reg_slice: self-checking bench for all four slice modes with a per-instance scoreboard
module tb_axi_reg_slice;
  logic        clk, rst, stall_clr;
  logic [31:0] du [4];
  logic [3:0]  vu, rd;
  wire  [3:0]  ru, vd;
  wire  [31:0] dd0, dd2, dd3;
  wire  [7:0]  dd1;
  logic [31:0] dd [4];
  wire  [31:0] sc0, sc1, sc2, sc3;
  int n_chk = 0, n_fail = 0;
  logic [31:0] q [1:3][$];
  logic [3:0]  pv = '0, pr = '0;
  logic [31:0] pd [4];
  always_comb begin
    dd[0] = dd0;
    dd[1] = {24'b0, dd1};
    dd[2] = dd2;
    dd[3] = dd3;
  end
  initial clk = 1'b0;
  always #5 clk = ~clk;
  axi_reg_slice #(.DATA_W(32), .MODE(0)) u0 (.clk(clk), .rst(rst), .data_up(du[0]), .valid_up(vu[0]),
    .ready_up(ru[0]), .data_down(dd0), .valid_down(vd[0]), .ready_down(rd[0])
`ifdef AXI_REG_SLICE_STALL_CNT_EN
    , .stall_clr(stall_clr), .stall_cnt(sc0)
`endif
  );
  axi_reg_slice #(.DATA_W(8), .MODE(1)) u1 (.clk(clk), .rst(rst), .data_up(du[1][7:0]), .valid_up(vu[1]),
    .ready_up(ru[1]), .data_down(dd1), .valid_down(vd[1]), .ready_down(rd[1])
`ifdef AXI_REG_SLICE_STALL_CNT_EN
    , .stall_clr(stall_clr), .stall_cnt(sc1)
`endif
  );
  axi_reg_slice #(.DATA_W(32), .MODE(2)) u2 (.clk(clk), .rst(rst), .data_up(du[2]), .valid_up(vu[2]),
    .ready_up(ru[2]), .data_down(dd2), .valid_down(vd[2]), .ready_down(rd[2])
`ifdef AXI_REG_SLICE_STALL_CNT_EN
    , .stall_clr(stall_clr), .stall_cnt(sc2)
`endif
  );
  axi_reg_slice #(.DATA_W(32), .MODE(3)) u3 (.clk(clk), .rst(rst), .data_up(du[3]), .valid_up(vu[3]),
    .ready_up(ru[3]), .data_down(dd3), .valid_down(vd[3]), .ready_down(rd[3])
`ifdef AXI_REG_SLICE_STALL_CNT_EN
    , .stall_clr(stall_clr), .stall_cnt(sc3)
`endif
  );
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // sample one unit before each rising edge, when every handshake signal is settled
  always @(negedge clk) begin
    #4;
    for (int i = 1; i < 4; i++) begin
      if (rst) begin
        q[i].delete();
        pv[i] = 1'b0;
      end else begin
        if (pv[i] && !pr[i]) begin
          check($sformatf("hold_valid%0d", i), 32'(vd[i]), 1);
          check($sformatf("hold_data%0d", i), dd[i], pd[i]);
        end
        if (i == 1) check("fwd_ready_eq", 32'(ru[1]), 32'(rd[1] || !vd[1]));
        if (vu[i] && ru[i]) q[i].push_back(i == 1 ? du[i] & 32'hFF : du[i]);
        if (vd[i] && rd[i]) begin
          check($sformatf("sb_nonempty%0d", i), 32'(q[i].size() != 0), 1);
          if (q[i].size() != 0) check($sformatf("sb_data%0d", i), dd[i], q[i].pop_front());
        end
        pv[i] = vd[i];
        pr[i] = rd[i];
        pd[i] = dd[i];
      end
    end
  end
  typedef struct {
    logic [31:0] d;
    logic        v, r;
    logic [31:0] ed;
    logic        ev, er;
  } vec_t;
  vec_t tbl [6];
  logic [31:0] cur;
  logic [3:0]  ga;
  logic        acc;
  initial begin
    tbl[0] = '{32'hDEADBEEF, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1};
    tbl[1] = '{32'h12345678, 1'b1, 1'b0, 32'h12345678, 1'b1, 1'b0};
    tbl[2] = '{32'hFFFFFFFF, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b1};
    tbl[3] = '{32'h00000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0};
    tbl[4] = '{32'hA5A5A5A5, 1'b1, 1'b1, 32'hA5A5A5A5, 1'b1, 1'b1};
    tbl[5] = '{32'h5A5A5A5A, 1'b0, 1'b0, 32'h5A5A5A5A, 1'b0, 1'b0};
    rst = 1'b1;
    stall_clr = 1'b0;
    vu = '0;
    rd = '1;
    for (int i = 0; i < 4; i++) du[i] = '0;
    @(negedge clk);
    @(negedge clk);
    #4;
    for (int i = 1; i < 4; i++) begin
      check($sformatf("rst_ready%0d", i), 32'(ru[i]), 0);
      check($sformatf("rst_valid%0d", i), 32'(vd[i]), 0);
    end
    check("rst_data1", dd[1], 0);
    check("rst_data3", dd[3], 0);
`ifdef AXI_REG_SLICE_STALL_CNT_EN
    check("rst_cnt0", sc0, 0);
    check("rst_cnt1", sc1, 0);
    check("rst_cnt2", sc2, 0);
    check("rst_cnt3", sc3, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    #4;
    for (int i = 1; i < 4; i++) check($sformatf("rst_exit_ready%0d", i), 32'(ru[i]), 1);
    for (int k = 0; k < 6; k++) begin
      du[0] = tbl[k].d;
      vu[0] = tbl[k].v;
      rd[0] = tbl[k].r;
      #1;
      check($sformatf("byp_data%0d", k), dd[0], tbl[k].ed);
      check($sformatf("byp_valid%0d", k), 32'(vd[0]), 32'(tbl[k].ev));
      check($sformatf("byp_ready%0d", k), 32'(ru[0]), 32'(tbl[k].er));
    end
    vu[0] = 1'b0;
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      vu[3] = k < 8;
      du[3] = 32'(k);
      #4;
      if (k < 8) check("full_stream_ready", 32'(ru[3]), 1);
      if (k > 0 && k < 9) begin
        check("full_stream_valid", 32'(vd[3]), 1);
        check("full_stream_data", dd[3], 32'(k - 1));
      end
      if (k == 9) check("full_stream_idle", 32'(vd[3]), 0);
    end
    @(negedge clk);
    rd[3] = 1'b0;
    vu[3] = 1'b1;
    du[3] = 32'hA1;
    #4 check("full_a1_ready", 32'(ru[3]), 1);
    @(negedge clk);
    du[3] = 32'hA2;
    #4;
    check("full_a2_ready", 32'(ru[3]), 1);
    check("full_a1_out", dd[3], 32'hA1);
    @(negedge clk);
    du[3] = 32'hA3;
    #4 check("full_ready_drop", 32'(ru[3]), 0);
    @(negedge clk);
    #4;
    check("full_ready_low", 32'(ru[3]), 0);
    check("full_a1_held", dd[3], 32'hA1);
    @(negedge clk);
    rd[3] = 1'b1;
    #4 check("full_drain_a1", dd[3], 32'hA1);
    @(negedge clk);
    #4;
    check("full_drain_a2", dd[3], 32'hA2);
    check("full_ready_back", 32'(ru[3]), 1);
    @(negedge clk);
    vu[3] = 1'b0;
    #4;
    check("full_drain_a3", dd[3], 32'hA3);
    check("full_drain_a3_v", 32'(vd[3]), 1);
    @(negedge clk);
    #4 check("full_drain_idle", 32'(vd[3]), 0);
    cur = 32'h100;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      vu[2] = 1'b1;
      du[2] = cur;
      rd[2] = (k % 2) == 1;
      #4;
      if (ru[2]) cur = cur + 1;
    end
    @(negedge clk);
    vu[2] = 1'b0;
    rd[2] = 1'b1;
    repeat (3) @(negedge clk);
    acc = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (!vu[1] || acc) begin
        vu[1] = 1'($urandom_range(0, 1));
        du[1] = 32'($urandom_range(0, 255));
      end
      rd[1] = 1'($urandom_range(0, 1));
      #4 acc = vu[1] && ru[1];
    end
    @(negedge clk);
    vu[1] = 1'b0;
    rd[1] = 1'b1;
    repeat (3) @(negedge clk);
    ga = '0;
    rd[3:1] = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      for (int i = 1; i < 4; i++) begin
        if (k == 0 || ga[i]) du[i] = 32'hB0 + 32'(k);
        vu[i] = 1'b1;
      end
      #4 ga = vu & ru;
    end
    @(negedge clk);
    rst = 1'b1;
    vu[3:1] = '0;
    #4;
    for (int i = 1; i < 4; i++) check($sformatf("midrst_ready%0d", i), 32'(ru[i]), 0);
    @(negedge clk);
    rst = 1'b0;
    rd[3:1] = '1;
    #4;
    for (int i = 1; i < 4; i++) begin
      check($sformatf("midrst_valid%0d", i), 32'(vd[i]), 0);
      check($sformatf("midrst_ready_exit%0d", i), 32'(ru[i]), 1);
    end
    repeat (3) begin
      @(negedge clk);
      #4;
      for (int i = 1; i < 4; i++) check($sformatf("midrst_no_replay%0d", i), 32'(vd[i]), 0);
    end
`ifdef AXI_REG_SLICE_STALL_CNT_EN
    @(negedge clk);
    vu[1] = 1'b1;
    du[1] = 32'h55;
    rd[1] = 1'b0;
    stall_clr = 1'b1;
    @(negedge clk);
    vu[1] = 1'b0;
    stall_clr = 1'b0;
    #4 check("stall_cnt_start", sc1, 0);
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      #4 check("stall_cnt_inc", sc1, 32'(k));
    end
    @(negedge clk);
    rd[1] = 1'b1;
    #4 check("stall_cnt_five", sc1, 5);
    @(negedge clk);
    rd[1] = 1'b0;
    vu[1] = 1'b1;
    du[1] = 32'h66;
    #4 check("stall_cnt_idle", sc1, 5);
    @(negedge clk);
    vu[1] = 1'b0;
    #4 check("stall_cnt_hold", sc1, 5);
    @(negedge clk);
    stall_clr = 1'b1;
    @(negedge clk);
    stall_clr = 1'b0;
    #4 check("stall_cnt_clr", sc1, 0);
    @(negedge clk);
    rd[1] = 1'b1;
    repeat (3) @(negedge clk);
`endif
    #4;
    for (int i = 1; i < 4; i++) check($sformatf("sb_drained%0d", i), 32'(q[i].size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
